// File: rtl/spawn_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// spawn_scheduler_pkg
// Shared game definitions for the spawn scheduler and its interval timer:
//   - FSM state encoding (IDLE=0, WAIT=1, PICK=2, CHECK=3, HOLD=4, ISSUE=5)
//   - speed-level width
//   - fuel-tank select pattern on the top bits of the random byte
//   - saturating 8-bit add used to build the next spawn interval
// -----------------------------------------------------------------------------
package spawn_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_PICK  = 3'd2,
    ST_CHECK = 3'd3,
    ST_HOLD  = 3'd4,
    ST_ISSUE = 3'd5
  } state_e;

  localparam int unsigned SPEED_W      = 2;
  localparam logic [2:0]  FUEL_PATTERN = 3'b111;

  // 9-bit sum clamped to 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/spawn_interval_timer.sv
// -----------------------------------------------------------------------------
// spawn_interval_timer
// 8-bit frame countdown. A load sets the count; while run is high each tick
// decrements it. expire pulses combinationally on the tick that takes the
// count from 1 to 0, so a loaded value N expires on exactly the Nth tick.
// Ports:
//   clk, rst      clock, synchronous active-high reset (count -> 0)
//   load          load load_val this cycle (has priority over ticks)
//   load_val[7:0] value to load
//   run           countdown active (scheduler in WAIT)
//   tick          frame tick
//   expire        final tick of the interval
// -----------------------------------------------------------------------------
module spawn_interval_timer
  import spawn_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       run,
  input  logic       tick,
  output logic       expire
);

  logic [7:0] count_q;

  assign expire = run && tick && (count_q == 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (run && tick && (count_q != 8'd0)) begin
      count_q <= count_q - 8'd1;
    end
  end

endmodule

// File: rtl/spawn_scheduler.sv
// -----------------------------------------------------------------------------
// spawn_scheduler
// Decides when, where, how fast and what kind of object (rival car or fuel
// tank) to spawn, hands the request to the slot manager over valid/ready and
// tracks the number of live objects so the road never exceeds MAX_ACTIVE.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   frame_tick          one-cycle pulse per video frame
//   enable              game running; low parks the scheduler in IDLE
//   rand_in[7:0]        free-running pseudo-random byte
//   despawn             one-cycle pulse: an object left the screen
//   spawn_valid         request pending (high only in ISSUE)
//   spawn_ready         slot manager accepts the request
//   spawn_lane          lane index, never equal to the previous spawn's lane
//   spawn_speed[1:0]    speed level 0..3
//   spawn_fuel          1 = fuel tank, 0 = rival car
//   active_cnt[3:0]     live object count (saturates at 15)
//   state_dbg[2:0]      current FSM state encoding
// -----------------------------------------------------------------------------
module spawn_scheduler
  import spawn_scheduler_pkg::*;
#(
  parameter int unsigned LANE_W        = 2,
  parameter int unsigned MIN_INTERVAL  = 20,
  parameter logic [7:0]  INTERVAL_MASK = 8'h1F,
  parameter int unsigned MAX_ACTIVE    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [7:0]         rand_in,
  input  logic               despawn,
  output logic               spawn_valid,
  input  logic               spawn_ready,
  output logic [LANE_W-1:0]  spawn_lane,
  output logic [SPEED_W-1:0] spawn_speed,
  output logic               spawn_fuel,
  output logic [3:0]         active_cnt,
  output logic [2:0]         state_dbg
);

  localparam logic [7:0] MIN_IV  = 8'(MIN_INTERVAL);
  localparam logic [3:0] MAX_ACT = 4'(MAX_ACTIVE);

  state_e               state_q, state_d;
  logic [LANE_W-1:0]    last_lane_q;
  logic [LANE_W-1:0]    lane_q;
  logic [SPEED_W-1:0]   speed_q;
  logic                 fuel_q;
  logic [3:0]           cnt_q;

  logic                 handshake;
  logic                 room;
  logic                 timer_load;
  logic [7:0]           timer_load_val;
  logic                 timer_expire;
  logic [LANE_W-1:0]    lane_raw;
  logic [LANE_W-1:0]    lane_pick;
  logic                 cnt_inc;
  logic                 cnt_dec;

  assign spawn_valid = (state_q == ST_ISSUE);
  assign spawn_lane  = lane_q;
  assign spawn_speed = speed_q;
  assign spawn_fuel  = fuel_q;
  assign active_cnt  = cnt_q;
  assign state_dbg   = state_q;

  assign handshake = spawn_valid && spawn_ready;
  assign room      = (cnt_q < MAX_ACT);

  // Adding 1 in LANE_W bits gives the modulo-lane-count wrap for free.
  assign lane_raw  = rand_in[LANE_W-1:0];
  assign lane_pick = (lane_raw == last_lane_q) ? lane_raw + 1'b1 : lane_raw;

  spawn_interval_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_load_val),
    .run      (state_q == ST_WAIT),
    .tick     (frame_tick),
    .expire   (timer_expire)
  );

  always_comb begin
    state_d        = state_q;
    timer_load     = 1'b0;
    timer_load_val = MIN_IV;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          timer_load = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!enable)           state_d = ST_IDLE;
        else if (timer_expire) state_d = ST_PICK;
      end
      ST_PICK: begin
        state_d = enable ? ST_CHECK : ST_IDLE;
      end
      ST_CHECK: begin
        if (!enable)   state_d = ST_IDLE;
        else if (room) state_d = ST_ISSUE;
        else           state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!enable)   state_d = ST_IDLE;
        else if (room) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // The request is never withdrawn; enable only picks where to go after it.
        if (handshake) begin
          timer_load     = 1'b1;
          timer_load_val = sat_add8(MIN_IV, rand_in & INTERVAL_MASK);
          state_d        = enable ? ST_WAIT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload is captured once in PICK and held through CHECK/HOLD/ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q      <= '0;
      speed_q     <= '0;
      fuel_q      <= 1'b0;
      last_lane_q <= '0;
    end else begin
      if (state_q == ST_PICK) begin
        lane_q  <= lane_pick;
        speed_q <= rand_in[LANE_W+SPEED_W-1:LANE_W];
        fuel_q  <= (rand_in[7:5] == FUEL_PATTERN);
      end
      if (handshake) begin
        last_lane_q <= lane_q;
      end
    end
  end

  assign cnt_inc = handshake;
  assign cnt_dec = despawn && (cnt_q != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_inc && !cnt_dec) begin
      if (cnt_q != 4'hF) cnt_q <= cnt_q + 4'd1;
    end else if (cnt_dec && !cnt_inc) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

endmodule

// File: tb/tb_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spawn_scheduler
// Directed bench for spawn_scheduler. Instance dut uses default parameters;
// instance dut2 uses MIN_INTERVAL=250 to exercise the saturating interval.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_spawn_scheduler;

  logic       clk = 1'b0;
  logic       rst, frame_tick, enable, despawn, spawn_ready;
  logic [7:0] rand_in;
  logic       spawn_valid, spawn_fuel;
  logic [1:0] spawn_lane, spawn_speed;
  logic [3:0] active_cnt;
  logic [2:0] state_dbg;

  logic       rst2, tick2, en2, desp2, ready2;
  logic [7:0] rand2;
  logic       valid2, fuel2;
  logic [1:0] lane2, speed2;
  logic [3:0] cnt2;
  logic [2:0] st2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_PICK = 3'd2,
                         S_CHECK = 3'd3, S_HOLD = 3'd4, S_ISSUE = 3'd5;

  always #5 clk = ~clk;

  spawn_scheduler dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .rand_in(rand_in), .despawn(despawn), .spawn_valid(spawn_valid),
    .spawn_ready(spawn_ready), .spawn_lane(spawn_lane), .spawn_speed(spawn_speed),
    .spawn_fuel(spawn_fuel), .active_cnt(active_cnt), .state_dbg(state_dbg)
  );

  spawn_scheduler #(.MIN_INTERVAL(250)) dut2 (
    .clk(clk), .rst(rst2), .frame_tick(tick2), .enable(en2),
    .rand_in(rand2), .despawn(desp2), .spawn_valid(valid2),
    .spawn_ready(ready2), .spawn_lane(lane2), .spawn_speed(speed2),
    .spawn_fuel(fuel2), .active_cnt(cnt2), .state_dbg(st2)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps until the selected instance reaches state s; an expired budget fails.
  task automatic wait_state(input bit second, input logic [2:0] s, input int budget,
                            output int cycles);
    cycles = 0;
    while (((second ? st2 : state_dbg) !== s) && (cycles < budget)) begin
      step(1);
      cycles++;
    end
    chk("wait_state", second ? st2 : state_dbg, s);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; enable = 1'b0; despawn = 1'b0;
    spawn_ready = 1'b0; rand_in = 8'h00;
    rst2 = 1'b1; tick2 = 1'b0; en2 = 1'b0; desp2 = 1'b0; ready2 = 1'b0; rand2 = 8'h00;
    step(2);

    // Reset state
    chk("rst_state", state_dbg, S_IDLE);
    chk("rst_valid", spawn_valid, 0);
    chk("rst_lane", spawn_lane, 0);
    chk("rst_speed", spawn_speed, 0);
    chk("rst_fuel", spawn_fuel, 0);
    chk("rst_cnt", active_cnt, 0);

    // Despawn at zero is ignored (in IDLE)
    rst = 1'b0; despawn = 1'b1;
    step(1);
    despawn = 1'b0;
    chk("despawn_at_zero", active_cnt, 0);

    // First spawn: rand 06, interval 20
    enable = 1'b1; spawn_ready = 1'b1; rand_in = 8'h06;
    step(1);
    chk("idle_to_wait", state_dbg, S_WAIT);
    frame_tick = 1'b1;
    wait_state(1'b0, S_PICK, 300, cyc);
    chk("first_interval", cyc, 20);
    chk("pick_valid_low", spawn_valid, 0);
    step(1);
    chk("check_state", state_dbg, S_CHECK);
    chk("check_valid_low", spawn_valid, 0);
    step(1);
    chk("s1_valid", spawn_valid, 1);
    chk("s1_lane", spawn_lane, 2);
    chk("s1_speed", spawn_speed, 1);
    chk("s1_fuel", spawn_fuel, 0);
    step(1);                                  // handshake with tick high
    chk("s1_cnt", active_cnt, 1);
    chk("s1_valid_drop", spawn_valid, 0);
    chk("s1_to_wait", state_dbg, S_WAIT);
    wait_state(1'b0, S_PICK, 300, cyc);
    chk("second_interval", cyc, 26);

    // Second spawn: rand 06 again, last_lane=2 -> lane 3
    step(2);
    chk("s2_lane", spawn_lane, 3);
    chk("s2_speed", spawn_speed, 1);
    rand_in = 8'h03;                          // next interval 23
    step(1);
    chk("s2_cnt", active_cnt, 2);
    wait_state(1'b0, S_PICK, 300, cyc);
    chk("third_interval", cyc, 23);

    // Third spawn: rand 03, last_lane=3 -> lane 0 (wrap), with backpressure
    spawn_ready = 1'b0;
    step(2);
    chk("s3_valid", spawn_valid, 1);
    chk("s3_lane_wrap", spawn_lane, 0);
    chk("s3_speed", spawn_speed, 0);
    rand_in = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_valid", spawn_valid, 1);
      chk("bp_lane", spawn_lane, 0);
      chk("bp_speed", spawn_speed, 0);
      chk("bp_fuel", spawn_fuel, 0);
    end
    spawn_ready = 1'b1; despawn = 1'b1; rand_in = 8'h07;
    step(1);
    despawn = 1'b0;
    chk("hs_and_despawn_cnt", active_cnt, 2);
    chk("s3_to_wait", state_dbg, S_WAIT);

    // Fourth spawn: rand 07, last_lane=0 -> lane 3
    wait_state(1'b0, S_PICK, 300, cyc);
    step(2);
    chk("s4_lane", spawn_lane, 3);
    rand_in = 8'hE4;
    step(1);
    chk("s4_cnt", active_cnt, 3);

    // Fifth spawn: road full -> HOLD, then despawn releases it
    wait_state(1'b0, S_PICK, 300, cyc);
    step(1);
    step(1);
    chk("full_hold", state_dbg, S_HOLD);
    chk("full_valid_low", spawn_valid, 0);
    step(1);
    chk("hold_stays", state_dbg, S_HOLD);
    despawn = 1'b1; spawn_ready = 1'b0;
    step(1);
    despawn = 1'b0;
    chk("despawn_cnt", active_cnt, 2);
    step(1);
    chk("hold_release_valid", spawn_valid, 1);
    chk("s5_lane", spawn_lane, 0);
    chk("s5_speed", spawn_speed, 1);
    chk("s5_fuel", spawn_fuel, 1);

    // Enable dropped mid-ISSUE: request persists, single handshake, then IDLE
    enable = 1'b0;
    step(3);
    chk("abort_valid_held", spawn_valid, 1);
    chk("abort_state", state_dbg, S_ISSUE);
    spawn_ready = 1'b1;
    step(1);
    chk("abort_to_idle", state_dbg, S_IDLE);
    chk("abort_valid_drop", spawn_valid, 0);
    chk("abort_cnt", active_cnt, 3);
    step(2);
    chk("abort_stays_idle", state_dbg, S_IDLE);
    chk("abort_cnt_single", active_cnt, 3);

    // Reset mid-ISSUE
    enable = 1'b1; spawn_ready = 1'b0; rand_in = 8'h00;
    step(1);
    wait_state(1'b0, S_PICK, 300, cyc);
    chk("reenable_interval", cyc, 20);
    step(2);
    chk("reenable_hold", state_dbg, S_HOLD);
    despawn = 1'b1;
    step(1);
    despawn = 1'b0;
    step(1);
    chk("pre_rst_valid", spawn_valid, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_valid", spawn_valid, 0);
    chk("midrst_cnt", active_cnt, 0);
    chk("midrst_state", state_dbg, S_IDLE);

    // Enable dropped in WAIT returns to IDLE
    step(1);
    chk("wait_entry", state_dbg, S_WAIT);
    enable = 1'b0;
    step(1);
    chk("wait_abort", state_dbg, S_IDLE);
    frame_tick = 1'b0;

    // Saturating interval on the MIN_INTERVAL=250 instance
    rst2 = 1'b0; en2 = 1'b1; ready2 = 1'b1; rand2 = 8'hFF; tick2 = 1'b1;
    step(1);
    wait_state(1'b1, S_PICK, 600, cyc);
    chk("d2_first_interval", cyc, 250);
    step(3);                                   // CHECK, ISSUE, handshake
    chk("d2_cnt", cnt2, 1);
    wait_state(1'b1, S_PICK, 600, cyc);
    chk("d2_saturated_interval", cyc, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spawn_scheduler.md
Name: spawn_scheduler

Overview:
- Sequences rival-car and fuel-tank spawns for the road renderer.
- Consumes the free-running 8-bit pseudo-random byte and the per-frame tick.
- Decides when to spawn, which lane, at what speed and which object kind.
- Hands each spawn to the object-slot manager over a valid/ready handshake and tracks the live object count so the road is never over-filled.

Parameters:
- LANE_W, 2, log2 of lane count; lanes = 2**LANE_W.
- MIN_INTERVAL, 20, minimum frames between spawn decisions (1..255).
- INTERVAL_MASK, 8'h1F, mask on the random byte added to MIN_INTERVAL.
- MAX_ACTIVE, 3, maximum live objects on screen (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- enable  in  1  game running; low = scheduler parked
- rand_in  in  8  pseudo-random byte, new value every clk
- despawn  in  1  one-cycle pulse: an object left the screen
- spawn_valid  out  1  spawn request pending
- spawn_ready  in  1  slot manager accepts the request
- spawn_lane  out  LANE_W  lane index
- spawn_speed  out  2  speed level 0..3
- spawn_fuel  out  1  1 = fuel tank, 0 = rival car
- active_cnt  out  4  live object count
- state_dbg  out  3  current FSM state encoding

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE; all spawn_* outputs 0; active_cnt=0.
  - frame counter=0; last_lane=0.
- FSM states: IDLE, WAIT, PICK, CHECK, HOLD, ISSUE.
- IDLE:
  - If enable=1, load counter=MIN_INTERVAL and go to WAIT.
- WAIT:
  - Each frame_tick decrements the counter.
  - The tick that takes the counter from 1 to 0 moves the FSM to PICK on that edge.
  - Counter value N therefore means exactly N frame_ticks.
- PICK (1 cycle): register rand_in into rsel.
  - lane_raw = rsel[LANE_W-1:0].
  - If lane_raw == last_lane, the lane is (lane_raw+1) mod 2**LANE_W; otherwise it is lane_raw.
  - speed = rsel[LANE_W+1:LANE_W].
  - fuel = (rsel[7:5] == 3'b111).
  - Go to CHECK.
- CHECK (1 cycle):
  - If active_cnt < MAX_ACTIVE, go to ISSUE.
  - Otherwise go to HOLD.
- HOLD:
  - Stay until active_cnt < MAX_ACTIVE, then go to ISSUE. The lane choice is kept.
- ISSUE:
  - spawn_valid=1. spawn_lane, spawn_speed and spawn_fuel are held stable until spawn_ready=1.
  - On the handshake cycle (valid & ready):
    - last_lane <= spawn_lane.
    - active_cnt increments.
    - counter <= min(255, MIN_INTERVAL + (rand_in & INTERVAL_MASK)), computed in 9 bits and saturated.
    - Go to WAIT.
    - spawn_valid drops on the next cycle.
- Latency: spawn_valid rises 2 clk after the WAIT→PICK edge (PICK, CHECK, then ISSUE).
- active_cnt rules:
  - +1 on handshake, -1 on despawn.
  - Both in the same cycle: unchanged.
  - despawn at 0 is ignored.
  - The count saturates at 15.
  - It updates in every state, including IDLE.
- enable=0 in WAIT/PICK/CHECK/HOLD: go to IDLE next edge; no spawn is issued.
- enable=0 in ISSUE: the request stays up until the handshake, then go to IDLE instead of WAIT. valid is never withdrawn.
- frame_tick outside WAIT is ignored. frame_tick coinciding with the handshake does not decrement the new counter.
- rst mid-operation (including during ISSUE): all state returns to reset values on that edge. spawn_valid is low the following cycle.

Decomposition:
- Shared game package holds:
  - state encoding constants (IDLE=0, WAIT=1, PICK=2, CHECK=3, HOLD=4, ISSUE=5);
  - the speed-level width (2);
  - the fuel-select pattern 3'b111.
- One natural sub-module: spawn_interval_timer. It holds the 8-bit frame countdown with load, decrement-on-tick and an expiry pulse.
- The FSM, lane select and active_cnt logic stay in spawn_scheduler.

Test Plan:
- First spawn timing: rst, then enable=1, ready=1, rand_in=8'h06 constant.
  - spawn_valid rises 2 clk after the 20th frame_tick.
  - Request carries lane=2, speed=1, fuel=0.
  - Next interval is 26 frames.
- Lane repeat: second PICK with rand_in=8'h06 again (last_lane=2) → lane=3. With rand_in=8'h03 and last_lane=3 → lane=0 (wrap).
- Fuel and saturation: rand_in=8'hE4 → fuel=1, lane=0 (last_lane=3), speed=1. With MIN_INTERVAL=250 and rand_in=8'hFF at handshake → counter saturates to 255.
- Full road: active_cnt=3 (MAX_ACTIVE) at CHECK → FSM enters HOLD with spawn_valid=0. A despawn pulse then drops active_cnt to 2 and spawn_valid rises the next cycle.
- Backpressure and abort:
  - ready=0 for 5 cycles → valid and payload stable.
  - enable dropped mid-ISSUE → single handshake, then IDLE.
  - Simultaneous handshake and despawn → active_cnt unchanged.
- Reset mid-ISSUE: assert rst while spawn_valid=1 → next cycle spawn_valid=0, active_cnt=0, state_dbg=0.
